// File: rtl/mem_stage.sv
// Memory stage of the five-stage pipeline: EX/MEM and MEM/WB registers, data-cache
// request, miss stall, branch/jump resolution, halt tracking and forwarding taps.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
endpackage

package pipe_types_pkg;
  import cpu_types_pkg::*;

  typedef struct packed {
    word_t          pcPlusFour;
    word_t          BrAddr;
    word_t          newPc;
    word_t          aluOut;
    word_t          dmemstore;
    logic [15:0]    imm16;
    regbits_t       rt;
    regbits_t       rd;
    logic           RegDst;
    logic           RegWrite;
    logic           jal;
    logic           dREN;
    logic           dWEN;
    logic           flagZero;
    logic           halt;
    logic [1:0]     RegSrc;
    logic [2:0]     pcsrc;
  } ex_mem_t;

  typedef struct packed {
    word_t          pcPlusFour;
    word_t          aluOut;
    word_t          dmemload;
    logic [15:0]    imm16;
    regbits_t       rt;
    regbits_t       rd;
    logic           RegDst;
    logic           RegWrite;
    logic           jal;
    logic [1:0]     RegSrc;
    logic           halt;
  } mem_wb_t;
endpackage

module mem_stage
  import cpu_types_pkg::*;
  import pipe_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  ex_mem_t     ex_in,
  input  logic        ex_valid,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_busy,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output mem_wb_t     memwb_out,
  output logic        memwb_valid,
  output logic        fwd_mem_rw,
  output logic [4:0]  fwd_mem_reg,
  output logic [31:0] fwd_mem_data,
  output logic        fwd_wb_rw,
  output logic [4:0]  fwd_wb_reg,
  output logic [31:0] fwd_wb_data,
  output logic        halt,
  output logic [31:0] stall_cnt
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  function automatic logic [4:0] dst_sel(input logic jal, input logic regdst,
                                         input logic [4:0] rd, input logic [4:0] rt);
    if (jal)
      return 5'd31;
    else if (regdst)
      return rd;
    else
      return rt;
  endfunction

  function automatic logic [31:0] wb_sel(input logic [1:0] src, input logic [31:0] alu,
                                         input logic [31:0] ld, input logic [31:0] pc4,
                                         input logic [15:0] imm);
    case (src)
      2'd0:    return alu;
      2'd1:    return ld;
      2'd2:    return pc4;
      default: return {16'd0, imm};
    endcase
  endfunction

  logic [1:0]  state_q, state_d;
  ex_mem_t     exm_q, exm_d;
  logic        exm_valid_q, exm_valid_d;
  mem_wb_t     memwb_q, memwb_d;
  logic        memwb_valid_q, memwb_valid_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        halted;
  logic        req_active;
  logic        advance;
  logic        taken;
  logic [31:0] target;
  logic [4:0]  exm_dst;
  logic [4:0]  wb_dst;

  assign halted     = (state_q == ST_HALTED);
  assign req_active = exm_valid_q & (exm_q.dREN | exm_q.dWEN) & ~halted;
  assign mem_busy   = req_active & ~dhit;
  assign advance    = ~mem_busy & ~halted;

  assign dmemREN    = exm_valid_q & exm_q.dREN & ~halted;
  assign dmemWEN    = exm_valid_q & exm_q.dWEN & ~halted;
  assign dmemaddr   = exm_q.aluOut;
  assign dmemstore  = exm_q.dmemstore;

  always_comb begin
    taken  = 1'b0;
    target = 32'd0;
    case (exm_q.pcsrc)
      3'd1: begin
        taken  = exm_q.flagZero;
        target = exm_q.BrAddr;
      end
      3'd2: begin
        taken  = ~exm_q.flagZero;
        target = exm_q.BrAddr;
      end
      3'd3: begin
        taken  = 1'b1;
        target = exm_q.newPc;
      end
      3'd4: begin
        taken  = 1'b1;
        target = exm_q.aluOut;
      end
      default: begin
        taken  = 1'b0;
        target = 32'd0;
      end
    endcase
  end

  // Redirect only fires when the branch actually leaves EX/MEM this cycle.
  assign redirect    = advance & exm_valid_q & taken;
  assign redirect_pc = redirect ? target : 32'd0;

  // Loads cannot be forwarded from EX/MEM; their data does not exist yet.
  assign exm_dst      = dst_sel(exm_q.jal, exm_q.RegDst, exm_q.rd, exm_q.rt);
  assign fwd_mem_rw   = exm_valid_q & exm_q.RegWrite & (exm_dst != 5'd0) & (exm_q.RegSrc != 2'd1);
  assign fwd_mem_reg  = exm_dst;
  assign fwd_mem_data = wb_sel(exm_q.RegSrc, exm_q.aluOut, 32'd0, exm_q.pcPlusFour, exm_q.imm16);

  assign wb_dst       = dst_sel(memwb_q.jal, memwb_q.RegDst, memwb_q.rd, memwb_q.rt);
  assign fwd_wb_rw    = memwb_valid_q & memwb_q.RegWrite & (wb_dst != 5'd0);
  assign fwd_wb_reg   = wb_dst;
  assign fwd_wb_data  = wb_sel(memwb_q.RegSrc, memwb_q.aluOut, memwb_q.dmemload,
                               memwb_q.pcPlusFour, memwb_q.imm16);

  assign memwb_out   = memwb_q;
  assign memwb_valid = memwb_valid_q;
  assign halt        = halted;
  assign stall_cnt   = stall_cnt_q;

  always_comb begin
    exm_d         = exm_q;
    exm_valid_d   = exm_valid_q;
    memwb_d       = memwb_q;
    memwb_valid_d = memwb_valid_q;
    stall_cnt_d   = stall_cnt_q + {31'd0, mem_busy};
    if (advance) begin
      memwb_d.pcPlusFour = exm_q.pcPlusFour;
      memwb_d.aluOut     = exm_q.aluOut;
      memwb_d.dmemload   = dmemload;
      memwb_d.imm16      = exm_q.imm16;
      memwb_d.rt         = exm_q.rt;
      memwb_d.rd         = exm_q.rd;
      memwb_d.RegDst     = exm_q.RegDst;
      memwb_d.RegWrite   = exm_q.RegWrite;
      memwb_d.jal        = exm_q.jal;
      memwb_d.RegSrc     = exm_q.RegSrc;
      memwb_d.halt       = exm_q.halt;
      memwb_valid_d      = exm_valid_q;
      exm_d              = ex_in;
      exm_valid_d        = ex_valid & ~redirect;
    end else if (halted) begin
      // The halt entry is shown for exactly one cycle, then the stage goes quiet.
      memwb_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (advance && exm_valid_q && exm_q.halt)
          state_d = ST_HALTED;
        else if (mem_busy)
          state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (advance && exm_valid_q && exm_q.halt)
          state_d = ST_HALTED;
        else if (dhit)
          state_d = ST_RUN;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_RUN;
      exm_q         <= '0;
      exm_valid_q   <= 1'b0;
      memwb_q       <= '0;
      memwb_valid_q <= 1'b0;
      stall_cnt_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      exm_q         <= exm_d;
      exm_valid_q   <= exm_valid_d;
      memwb_q       <= memwb_d;
      memwb_valid_q <= memwb_valid_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage, checked every cycle against an
// instruction-level model of the memory stage.
module tb_mem_stage;
  import cpu_types_pkg::*;
  import pipe_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  ex_mem_t     ex_in = '0;
  logic        ex_valid = 1'b0;
  logic        dhit = 1'b0;
  logic [31:0] dmemload = 32'd0;
  logic        dmemREN, dmemWEN, mem_busy, redirect, memwb_valid;
  logic [31:0] dmemaddr, dmemstore, redirect_pc, fwd_mem_data, fwd_wb_data, stall_cnt;
  mem_wb_t     memwb_out;
  logic        fwd_mem_rw, fwd_wb_rw, halt;
  logic [4:0]  fwd_mem_reg, fwd_wb_reg;

  int errs = 0;
  int checks = 0;
  logic check_en = 1'b0;

  mem_stage dut (
    .CLK(CLK), .RST(RST), .ex_in(ex_in), .ex_valid(ex_valid), .dhit(dhit),
    .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_busy(mem_busy), .redirect(redirect),
    .redirect_pc(redirect_pc), .memwb_out(memwb_out), .memwb_valid(memwb_valid),
    .fwd_mem_rw(fwd_mem_rw), .fwd_mem_reg(fwd_mem_reg), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_rw(fwd_wb_rw), .fwd_wb_reg(fwd_wb_reg), .fwd_wb_data(fwd_wb_data),
    .halt(halt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errs);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  ex_mem_t     m_exm;
  logic        m_exm_v;
  mem_wb_t     m_wb;
  logic        m_wb_v;
  logic        m_halted;
  logic [31:0] m_stalls;

  function automatic logic [4:0] m_dst(input logic jal, input logic rdst,
                                       input logic [4:0] rd, input logic [4:0] rt);
    return jal ? 5'd31 : (rdst ? rd : rt);
  endfunction

  function automatic logic [31:0] m_val(input logic [1:0] src, input logic [31:0] alu,
                                        input logic [31:0] ld, input logic [31:0] pc4,
                                        input logic [15:0] imm);
    logic [31:0] imm_ext;
    imm_ext = {16'd0, imm};
    return (src == 2'd0) ? alu : (src == 2'd1) ? ld : (src == 2'd2) ? pc4 : imm_ext;
  endfunction

  function automatic logic m_busy();
    return m_exm_v && !m_halted && (m_exm.dREN || m_exm.dWEN) && !dhit;
  endfunction

  function automatic logic m_taken();
    return (m_exm.pcsrc == 3'd1 && m_exm.flagZero) || (m_exm.pcsrc == 3'd2 && !m_exm.flagZero)
        || m_exm.pcsrc == 3'd3 || m_exm.pcsrc == 3'd4;
  endfunction

  function automatic logic [31:0] m_target();
    return (m_exm.pcsrc == 3'd3) ? m_exm.newPc : (m_exm.pcsrc == 3'd4) ? m_exm.aluOut : m_exm.BrAddr;
  endfunction

  function automatic logic m_redirect();
    return !m_busy() && !m_halted && m_exm_v && m_taken();
  endfunction

  function automatic mem_wb_t m_retire(input ex_mem_t e, input logic [31:0] ld);
    mem_wb_t w;
    w.pcPlusFour = e.pcPlusFour; w.aluOut = e.aluOut; w.dmemload = ld;
    w.imm16 = e.imm16; w.rt = e.rt; w.rd = e.rd; w.RegDst = e.RegDst;
    w.RegWrite = e.RegWrite; w.jal = e.jal; w.RegSrc = e.RegSrc; w.halt = e.halt;
    return w;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_exm <= '0; m_exm_v <= 1'b0; m_wb <= '0; m_wb_v <= 1'b0;
      m_halted <= 1'b0; m_stalls <= 32'd0;
    end else begin
      if (m_busy()) m_stalls <= m_stalls + 32'd1;
      if (!m_busy() && !m_halted) begin
        m_wb    <= m_retire(m_exm, dmemload);
        m_wb_v  <= m_exm_v;
        m_exm   <= ex_in;
        m_exm_v <= ex_valid && !m_redirect();
        if (m_exm_v && m_exm.halt) m_halted <= 1'b1;
      end else if (m_halted) begin
        m_wb_v <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (check_en) begin
      chk("dmemREN", dmemREN, m_exm_v && !m_halted && m_exm.dREN);
      chk("dmemWEN", dmemWEN, m_exm_v && !m_halted && m_exm.dWEN);
      if (m_exm_v && !m_halted && (m_exm.dREN || m_exm.dWEN)) begin
        chk("dmemaddr", dmemaddr, m_exm.aluOut);
        chk("dmemstore", dmemstore, m_exm.dmemstore);
      end
      chk("mem_busy", mem_busy, m_busy());
      chk("redirect", redirect, m_redirect());
      if (m_redirect()) chk("redirect_pc", redirect_pc, m_target());
      chk("memwb_out", memwb_out, m_wb);
      chk("memwb_valid", memwb_valid, m_wb_v);
      chk("fwd_mem_rw", fwd_mem_rw, m_exm_v && m_exm.RegWrite && m_exm.RegSrc != 2'd1
          && m_dst(m_exm.jal, m_exm.RegDst, m_exm.rd, m_exm.rt) != 5'd0);
      chk("fwd_mem_reg", fwd_mem_reg, m_dst(m_exm.jal, m_exm.RegDst, m_exm.rd, m_exm.rt));
      if (m_exm.RegSrc != 2'd1)
        chk("fwd_mem_data", fwd_mem_data,
            m_val(m_exm.RegSrc, m_exm.aluOut, 32'd0, m_exm.pcPlusFour, m_exm.imm16));
      chk("fwd_wb_rw", fwd_wb_rw, m_wb_v && m_wb.RegWrite
          && m_dst(m_wb.jal, m_wb.RegDst, m_wb.rd, m_wb.rt) != 5'd0);
      chk("fwd_wb_reg", fwd_wb_reg, m_dst(m_wb.jal, m_wb.RegDst, m_wb.rd, m_wb.rt));
      chk("fwd_wb_data", fwd_wb_data,
          m_val(m_wb.RegSrc, m_wb.aluOut, m_wb.dmemload, m_wb.pcPlusFour, m_wb.imm16));
      chk("halt", halt, m_halted);
      chk("stall_cnt", stall_cnt, m_stalls);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; ex_valid = 1'b0; ex_in = '0; dhit = 1'b0;
    cyc(); cyc();
    RST = 1'b0;
  endtask

  function automatic ex_mem_t mk_alu(input logic [31:0] alu, input logic [4:0] rd);
    ex_mem_t e;
    e = '0; e.aluOut = alu; e.rd = rd; e.RegDst = 1'b1; e.RegWrite = 1'b1;
    return e;
  endfunction

  function automatic ex_mem_t rand_ex();
    ex_mem_t e;
    e.pcPlusFour = $urandom; e.BrAddr = $urandom; e.newPc = $urandom;
    e.aluOut = $urandom; e.dmemstore = $urandom; e.imm16 = 16'($urandom);
    e.rt = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    e.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    e.RegDst = 1'($urandom); e.RegWrite = 1'($urandom); e.jal = ($urandom_range(0, 9) == 0);
    e.dREN = ($urandom_range(0, 3) == 0);
    e.dWEN = !e.dREN && ($urandom_range(0, 4) == 0);
    e.flagZero = 1'($urandom); e.halt = ($urandom_range(0, 150) == 0);
    e.RegSrc = 2'($urandom); e.pcsrc = 3'($urandom_range(0, 7));
    return e;
  endfunction

  initial begin
    ex_mem_t t;
    do_reset();
    check_en = 1'b1;

    // Reset state
    @(negedge CLK);
    chk("rst_memwb_valid", memwb_valid, 1'b0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_dmemaddr", dmemaddr, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    $display("scenario: reset state");

    // ALU op, no stall
    do_reset();
    ex_in = mk_alu(32'h10, 5'd5); ex_valid = 1'b1;
    cyc();
    ex_valid = 1'b0; ex_in = '0;
    @(negedge CLK);
    chk("alu_fwd_mem_reg", fwd_mem_reg, 5'd5);
    chk("alu_fwd_mem_rw", fwd_mem_rw, 1'b1);
    chk("alu_memwb_valid_early", memwb_valid, 1'b0);
    cyc();
    @(negedge CLK);
    chk("alu_memwb_valid", memwb_valid, 1'b1);
    chk("alu_fwd_wb_data", fwd_wb_data, 32'h10);
    chk("alu_fwd_wb_reg", fwd_wb_reg, 5'd5);
    $display("scenario: ALU op, no stall");

    // Load miss for three cycles
    do_reset();
    t = '0; t.aluOut = 32'h100; t.dREN = 1'b1; t.RegSrc = 2'd1; t.RegWrite = 1'b1; t.rt = 5'd8;
    ex_in = t; ex_valid = 1'b1; dhit = 1'b0;
    cyc();
    ex_in = mk_alu(32'h55, 5'd9); ex_valid = 1'b1;
    @(negedge CLK);
    chk("lw_dmemREN", dmemREN, 1'b1);
    chk("lw_dmemaddr", dmemaddr, 32'h100);
    chk("lw_mem_busy", mem_busy, 1'b1);
    chk("lw_fwd_mem_rw", fwd_mem_rw, 1'b0);
    cyc(); cyc(); cyc();
    dhit = 1'b1; dmemload = 32'hDEADBEEF;
    @(negedge CLK);
    chk("lw_busy_released", mem_busy, 1'b0);
    chk("lw_stall_cnt", stall_cnt, 32'd3);
    cyc();
    dhit = 1'b0; ex_valid = 1'b0; ex_in = '0; dmemload = 32'd0;
    @(negedge CLK);
    chk("lw_memwb_valid", memwb_valid, 1'b1);
    chk("lw_fwd_wb_data", fwd_wb_data, 32'hDEADBEEF);
    chk("lw_fwd_wb_reg", fwd_wb_reg, 5'd8);
    chk("lw_held_reg", fwd_mem_reg, 5'd9);
    chk("lw_held_data", fwd_mem_data, 32'h55);
    cyc();
    @(negedge CLK);
    chk("lw_next_wb_data", fwd_wb_data, 32'h55);
    chk("lw_stall_final", stall_cnt, 32'd3);
    $display("scenario: load miss, 3 stall cycles");

    // Store hit in the same cycle
    do_reset();
    t = '0; t.aluOut = 32'h200; t.dWEN = 1'b1; t.dmemstore = 32'hCAFEF00D;
    ex_in = t; ex_valid = 1'b1;
    cyc();
    ex_valid = 1'b0; ex_in = '0; dhit = 1'b1;
    @(negedge CLK);
    chk("sw_dmemWEN", dmemWEN, 1'b1);
    chk("sw_dmemstore", dmemstore, 32'hCAFEF00D);
    chk("sw_mem_busy", mem_busy, 1'b0);
    cyc();
    dhit = 1'b0;
    @(negedge CLK);
    chk("sw_dmemWEN_drop", dmemWEN, 1'b0);
    chk("sw_stall_cnt", stall_cnt, 32'd0);
    $display("scenario: store hit same cycle");

    // Taken and not-taken BEQ
    do_reset();
    t = '0; t.pcsrc = 3'd1; t.flagZero = 1'b1; t.BrAddr = 32'h40;
    ex_in = t; ex_valid = 1'b1;
    cyc();
    ex_in = mk_alu(32'h77, 5'd9); ex_valid = 1'b1;
    @(negedge CLK);
    chk("beq_redirect", redirect, 1'b1);
    chk("beq_redirect_pc", redirect_pc, 32'h40);
    cyc();
    ex_valid = 1'b0;
    @(negedge CLK);
    chk("beq_redirect_once", redirect, 1'b0);
    chk("beq_squash", fwd_mem_rw, 1'b0);
    t.flagZero = 1'b0; ex_in = t; ex_valid = 1'b1;
    cyc();
    ex_in = mk_alu(32'h77, 5'd9); ex_valid = 1'b1;
    @(negedge CLK);
    chk("bne_no_redirect", redirect, 1'b0);
    cyc();
    ex_valid = 1'b0;
    @(negedge CLK);
    chk("bne_kept_rw", fwd_mem_rw, 1'b1);
    chk("bne_kept_reg", fwd_mem_reg, 5'd9);
    $display("scenario: branch taken / not taken");

    // Halt followed by valid ops
    do_reset();
    t = '0; t.halt = 1'b1;
    ex_in = t; ex_valid = 1'b1;
    cyc();
    t = '0; t.dREN = 1'b1; t.aluOut = 32'h300;
    ex_in = t; ex_valid = 1'b1;
    @(negedge CLK);
    chk("halt_not_yet", halt, 1'b0);
    cyc();
    @(negedge CLK);
    chk("halt_set", halt, 1'b1);
    chk("halt_wb_flag", memwb_out.halt, 1'b1);
    chk("halt_memwb_valid", memwb_valid, 1'b1);
    chk("halt_no_req", dmemREN, 1'b0);
    cyc();
    ex_in = mk_alu(32'h1, 5'd3);
    @(negedge CLK);
    chk("halt_wb_drop", memwb_valid, 1'b0);
    cyc(); cyc();
    @(negedge CLK);
    chk("halt_sticky", halt, 1'b1);
    chk("halt_still_quiet", memwb_valid, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    chk("halt_rst_halt", halt, 1'b0);
    chk("halt_rst_memwb", memwb_out, 159'd0);
    cyc();
    RST = 1'b0; ex_valid = 1'b0;
    $display("scenario: halt then reset");

    // Reset mid-WAIT, then a fresh load
    do_reset();
    t = '0; t.dREN = 1'b1; t.aluOut = 32'h400; t.RegSrc = 2'd1; t.RegWrite = 1'b1; t.rt = 5'd4;
    ex_in = t; ex_valid = 1'b1; dhit = 1'b0;
    cyc();
    ex_valid = 1'b0;
    @(negedge CLK);
    chk("rstw_req", dmemREN, 1'b1);
    #1 RST = 1'b1;
    #1;
    chk("rstw_req_drop", dmemREN, 1'b0);
    chk("rstw_busy_drop", mem_busy, 1'b0);
    cyc();
    RST = 1'b0;
    ex_valid = 1'b1;
    cyc();
    ex_valid = 1'b0; dhit = 1'b1; dmemload = 32'h12345678;
    @(negedge CLK);
    chk("rstw_fresh_busy", mem_busy, 1'b0);
    cyc();
    dhit = 1'b0;
    @(negedge CLK);
    chk("rstw_fresh_valid", memwb_valid, 1'b1);
    chk("rstw_fresh_data", fwd_wb_data, 32'h12345678);
    $display("scenario: reset during pending load");

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 399) == 0) begin
        $display("random: reset at cycle %0d (halted=%0d)", i, m_halted);
        do_reset();
      end
      ex_in    = rand_ex();
      ex_valid = ($urandom_range(0, 3) != 0);
      dhit     = ($urandom_range(0, 2) != 0);
      dmemload = $urandom;
      cyc();
    end
    $display("scenario: random traffic, 3000 cycles");

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
